// File: rtl/lock_display_scan.sv
// Multiplexed 8-digit display driver for the lock controller.
// A prescaler produces one scan tick per digit slot; the digit index walks
// 0..7, and the lock inputs are captured into shadow registers only when the
// index returns to 0, so a frame never mixes old and new content.
// AN, SEG and LD are registered on the scan tick that selects the new slot.
module lock_display_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  MODE,
  input  logic [15:0] CODE,
  input  logic [2:0]  CODE_BIT,
  input  logic [1:0]  ERR_CNT,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic [15:0] LD
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    M_WAIT   = 3'd0,
    M_INPUT  = 3'd1,
    M_UNLOCK = 3'd2,
    M_ERROR  = 3'd3,
    M_ALARM  = 3'd4
  } mode_t;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  mode_t         r_sh_mode;
  logic [15:0]   r_sh_code;
  logic [2:0]    r_sh_cbit;
  logic [1:0]    r_sh_err;
  logic [BW-1:0] r_blink;
  logic          r_phase;
  logic [7:0]    r_an;
  logic [7:0]    r_seg;
  logic [15:0]   r_ld;

  logic          w_tick;
  logic [2:0]    w_idx_nxt;
  logic          w_frame;
  mode_t         w_mode_in;
  logic [2:0]    w_cbit_in;
  mode_t         w_sh_mode;
  logic [15:0]   w_sh_code;
  logic [2:0]    w_sh_cbit;
  logic [1:0]    w_sh_err;
  logic          w_mode_chg;
  logic [BW-1:0] w_blink_nxt;
  logic          w_phase_nxt;
  logic [3:0]    w_nib;
  logic [1:0]    w_k;
  logic          w_blank;
  logic          w_blinks;
  logic [7:0]    w_glyph;
  logic [7:0]    w_an;
  logic [7:0]    w_seg;
  logic [15:0]   w_ld;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_idx_nxt = w_tick ? (r_idx + 3'd1) : r_idx;
  // The frame starts when the index wraps from 7 back to 0.
  assign w_frame   = w_tick && (r_idx == 3'd7);
  assign w_cbit_in = (CODE_BIT > 3'd4) ? 3'd4 : CODE_BIT;

  // Undefined mode codes fall back to the idle dash pattern.
  always_comb begin
    case (MODE)
      3'd1:    w_mode_in = M_INPUT;
      3'd2:    w_mode_in = M_UNLOCK;
      3'd3:    w_mode_in = M_ERROR;
      3'd4:    w_mode_in = M_ALARM;
      default: w_mode_in = M_WAIT;
    endcase
  end

  // Slot 0 must already show the freshly captured inputs, so content is
  // computed from the values the shadows are about to take.
  assign w_sh_mode = w_frame ? w_mode_in : r_sh_mode;
  assign w_sh_code = w_frame ? CODE      : r_sh_code;
  assign w_sh_cbit = w_frame ? w_cbit_in : r_sh_cbit;
  assign w_sh_err  = w_frame ? ERR_CNT   : r_sh_err;

  // Prescaler: one scan tick every SCAN_DIV clocks.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Digit index and frame-start capture of the lock inputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_idx     <= 3'd7;
      r_sh_mode <= M_WAIT;
      r_sh_code <= '0;
      r_sh_cbit <= '0;
      r_sh_err  <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_frame) begin
        r_sh_mode <= w_mode_in;
        r_sh_code <= CODE;
        r_sh_cbit <= w_cbit_in;
        r_sh_err  <= ERR_CNT;
      end
    end
  end

  // Blink timer counts scan ticks; a new mode restarts it in the on-phase.
  always_comb begin
    w_mode_chg  = w_frame && (w_mode_in != r_sh_mode);
    w_blink_nxt = r_blink;
    w_phase_nxt = r_phase;
    if (w_tick) begin
      if (w_mode_chg) begin
        w_blink_nxt = '0;
        w_phase_nxt = 1'b1;
      end else if (r_blink == BLINK_LAST) begin
        w_blink_nxt = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_blink_nxt = r_blink + BW'(1);
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_blink <= '0;
      r_phase <= 1'b1;
    end else begin
      r_blink <= w_blink_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Glyph, digit enable and LED pattern for the slot being selected.
  always_comb begin
    w_blank  = 1'b0;
    w_blinks = 1'b0;
    w_glyph  = 8'hBF;
    w_ld     = 16'h0000;
    w_nib    = w_sh_code[{w_idx_nxt[1:0], 2'b00} +: 4];
    w_k      = 2'd3 - w_idx_nxt[1:0];
    case (w_sh_mode)
      M_INPUT: begin
        w_blank = w_idx_nxt[2];
        w_glyph = ({1'b0, w_k} < w_sh_cbit) ? f_hex(w_nib) : 8'hF7;
        case (w_sh_cbit)
          3'd1:    w_ld = 16'h0001;
          3'd2:    w_ld = 16'h0003;
          3'd3:    w_ld = 16'h0007;
          3'd4:    w_ld = 16'h000F;
          default: w_ld = 16'h0000;
        endcase
      end
      M_UNLOCK: begin
        w_blank = w_idx_nxt[2];
        case (w_idx_nxt[1:0])
          2'd3:    w_glyph = 8'hC0;
          2'd2:    w_glyph = 8'h8C;
          2'd1:    w_glyph = 8'h86;
          default: w_glyph = 8'hAB;
        endcase
        w_ld = 16'hFFFF;
      end
      M_ERROR: begin
        w_blank  = w_idx_nxt[2];
        w_blinks = 1'b1;
        case (w_idx_nxt[1:0])
          2'd3:    w_glyph = 8'h86;
          2'd2:    w_glyph = 8'hAF;
          2'd1:    w_glyph = 8'hAF;
          default: w_glyph = f_hex({2'b00, w_sh_err});
        endcase
        w_ld = {w_sh_err, 14'd0};
      end
      M_ALARM: begin
        w_blinks = 1'b1;
        w_glyph  = 8'h00;
        w_ld     = w_phase_nxt ? 16'hFFFF : 16'h0000;
      end
      default: begin
        w_glyph = 8'hBF;
        w_ld    = 16'h0000;
      end
    endcase
    if (w_blank) begin
      w_an  = 8'hFF;
      w_seg = 8'hFF;
    end else begin
      w_an  = ~(8'h01 << w_idx_nxt);
      w_seg = w_glyph;
    end
    if (w_blinks && !w_phase_nxt) w_an = 8'hFF;
  end

  // Output registers load once per scan tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
      r_ld  <= 16'h0000;
    end else if (w_tick) begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_ld  <= w_ld;
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign LD  = r_ld;

endmodule
